// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline hazard signal bundle between datapath and stall unit
interface hazard_stall_unit_if;
  logic        idexmemread;
  logic [4:0]  idexrt;
  logic [4:0]  ifidrs;
  logic [4:0]  ifidrt;
  logic        ifidusesrt;
  logic        branchtaken;
  logic        exmemaccess;
  logic        dmemready;
  logic        pcwrite;
  logic        ifidwrite;
  logic        idexbubble;
  logic        ifidflush;
  logic        freeze;
  logic [1:0]  state;
  logic [15:0] stallcycles;
  logic [7:0]  flushcount;
  logic        memtimeout;

  modport master (
    output idexmemread, idexrt, ifidrs, ifidrt, ifidusesrt,
           branchtaken, exmemaccess, dmemready,
    input  pcwrite, ifidwrite, idexbubble, ifidflush, freeze,
           state, stallcycles, flushcount, memtimeout
  );

  modport slave (
    input  idexmemread, idexrt, ifidrs, ifidrt, ifidusesrt,
           branchtaken, exmemaccess, dmemready,
    output pcwrite, ifidwrite, idexbubble, ifidflush, freeze,
           state, stallcycles, flushcount, memtimeout
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / branch / memory-wait stall control with statistics
module hazard_stall_unit (
  input  logic                  clock,
  input  logic                  reset,
  hazard_stall_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LUSTALL = 2'd1,
    MEMWAIT = 2'd2,
    BRFLUSH = 2'd3
  } state_t;

  state_t      cur_state;
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;
  logic [7:0]  memwait_cnt;
  logic        timeout_flag;

  logic memstall;
  logic rt_match;
  logic loaduse;
  logic branch_flush;

  assign memstall = bus.exmemaccess & ~bus.dmemready;

  assign rt_match = (bus.idexrt == bus.ifidrs) |
                    (bus.ifidusesrt & (bus.idexrt == bus.ifidrt));

  // The bubble already inserted covers the hazard, so a repeat match while
  // stalled must not insert a second one.
  assign loaduse = bus.idexmemread & (bus.idexrt != 5'd0) & rt_match &
                   (cur_state != LUSTALL);

  // A frozen EX stage means a taken branch is not acted on yet.
  assign branch_flush = bus.branchtaken & ~memstall;

  always_comb begin
    bus.pcwrite    = 1'b1;
    bus.ifidwrite  = 1'b1;
    bus.idexbubble = 1'b0;
    bus.ifidflush  = 1'b0;
    bus.freeze     = 1'b0;
    if (reset) begin
      bus.pcwrite    = 1'b0;
      bus.ifidwrite  = 1'b0;
      bus.idexbubble = 1'b1;
      bus.ifidflush  = 1'b1;
    end else if (memstall) begin
      bus.freeze     = 1'b1;
      bus.pcwrite    = 1'b0;
      bus.ifidwrite  = 1'b0;
    end else if (bus.branchtaken) begin
      bus.ifidflush  = 1'b1;
      bus.idexbubble = 1'b1;
    end else if (loaduse) begin
      bus.pcwrite    = 1'b0;
      bus.ifidwrite  = 1'b0;
      bus.idexbubble = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state    <= RUN;
      stall_cnt    <= 16'd0;
      flush_cnt    <= 8'd0;
      memwait_cnt  <= 8'd0;
      timeout_flag <= 1'b0;
    end else begin
      if (memstall)
        cur_state <= MEMWAIT;
      else if (bus.branchtaken)
        cur_state <= BRFLUSH;
      else if (loaduse)
        cur_state <= LUSTALL;
      else
        cur_state <= RUN;

      if (!bus.pcwrite && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;

      if (branch_flush && flush_cnt != 8'hFF)
        flush_cnt <= flush_cnt + 8'd1;

      if (memstall) begin
        if (memwait_cnt != 8'hFF)
          memwait_cnt <= memwait_cnt + 8'd1;
        if (memwait_cnt == 8'hFE)
          timeout_flag <= 1'b1;
      end else begin
        memwait_cnt <= 8'd0;
      end
    end
  end

  assign bus.state       = cur_state;
  assign bus.stallcycles = stall_cnt;
  assign bus.flushcount  = flush_cnt;
  assign bus.memtimeout  = timeout_flag;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - randomized and directed self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hazard_stall_unit_if hif();
  hazard_stall_unit dut (.clock(clock), .reset(reset), .bus(hif.slave));

  int total = 0;
  int bad   = 0;

  // Reference view of the unit: named stall situation plus plain counters.
  int m_state;
  int m_stall;
  int m_flush;
  int m_wait;
  int m_to;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit mr, input int rt, input int rs, input int rtt,
                       input bit usesrt, input bit br, input bit acc, input bit rdy);
    hif.idexmemread = mr;
    hif.idexrt      = 5'(rt);
    hif.ifidrs      = 5'(rs);
    hif.ifidrt      = 5'(rtt);
    hif.ifidusesrt  = usesrt;
    hif.branchtaken = br;
    hif.exmemaccess = acc;
    hif.dmemready   = rdy;
  endtask

  function automatic int sat_inc(int v, int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Checks one cycle against the model, then advances the model over the edge.
  task automatic cycle();
    bit waiting, hazard, pc_held;
    int situation;
    logic [4:0] exp_ctl;
    #4;
    waiting = hif.exmemaccess && !hif.dmemready;
    hazard  = hif.idexmemread && hif.idexrt != 0 && m_state != 1 &&
              (hif.ifidrs == hif.idexrt || (hif.ifidusesrt && hif.ifidrt == hif.idexrt));
    if (reset)                situation = 4;
    else if (waiting)         situation = 2;
    else if (hif.branchtaken) situation = 3;
    else if (hazard)          situation = 1;
    else                      situation = 0;
    // {pcwrite, ifidwrite, idexbubble, ifidflush, freeze}
    case (situation)
      0: exp_ctl = 5'b11000;
      1: exp_ctl = 5'b00100;
      2: exp_ctl = 5'b00001;
      3: exp_ctl = 5'b11110;
      default: exp_ctl = 5'b00110;
    endcase
    check("ctl", {hif.pcwrite, hif.ifidwrite, hif.idexbubble, hif.ifidflush, hif.freeze}, exp_ctl);
    check("state", hif.state, m_state);
    check("stallcycles", hif.stallcycles, m_stall);
    check("flushcount", hif.flushcount, m_flush);
    check("memtimeout", hif.memtimeout, m_to);
    pc_held = !exp_ctl[4];
    @(posedge clock);
    #1;
    if (situation == 4) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
    end else begin
      m_state = (situation == 4) ? 0 : situation;
      if (pc_held) m_stall = sat_inc(m_stall, 65535);
      if (situation == 3) m_flush = sat_inc(m_flush, 255);
      m_wait = waiting ? sat_inc(m_wait, 255) : 0;
      if (m_wait == 255) m_to = 1;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 3, 3, 0, 0, 1, 1, 0);
    #2;
    check("reset_pcwrite", hif.pcwrite, 0);
    check("reset_ifidflush", hif.ifidflush, 1);
    check("reset_bubble", hif.idexbubble, 1);
    check("reset_freeze", hif.freeze, 0);
    @(posedge clock);
    #1;
    m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
    check("reset_state", hif.state, 0);
    check("reset_stall", hif.stallcycles, 0);
    reset = 1'b0;

    // load-use stall, single bubble
    drive(1, 5, 5, 0, 0, 0, 0, 1);
    #2;
    check("lu_pcwrite", hif.pcwrite, 0);
    check("lu_bubble", hif.idexbubble, 1);
    cycle();
    check("lu_state", hif.state, 1);
    #2;
    check("lu_no_second_bubble", hif.idexbubble, 0);
    cycle();
    check("lu_stallcycles", hif.stallcycles, 1);

    // r0 and unused rt never stall
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    #2;
    check("r0_pcwrite", hif.pcwrite, 1);
    cycle();
    drive(1, 7, 1, 7, 0, 0, 0, 1);
    #2;
    check("rt_unused_pcwrite", hif.pcwrite, 1);
    cycle();

    // branch beats load-use
    drive(1, 5, 5, 0, 0, 1, 0, 1);
    #2;
    check("br_flush", hif.ifidflush, 1);
    check("br_bubble", hif.idexbubble, 1);
    check("br_pcwrite", hif.pcwrite, 1);
    cycle();
    check("br_flushcount", hif.flushcount, 1);
    check("br_state", hif.state, 3);

    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // branch held off by memory stall
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #2;
      check("ms_freeze", hif.freeze, 1);
      cycle();
    end
    check("ms_flushcount", hif.flushcount, 0);
    check("ms_stallcycles", hif.stallcycles, 3);
    check("ms_state", hif.state, 2);
    for (int i = 0; i < 7; i++) cycle();
    check("ms_stall10", hif.stallcycles, 10);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_mid_state", hif.state, 0);
    check("rst_mid_stall", hif.stallcycles, 0);
    check("rst_mid_flush", hif.flushcount, 0);
    check("rst_mid_timeout", hif.memtimeout, 0);

    // memory timeout
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 300; i++) begin
      cycle();
      if (i == 254) check("to_254", hif.memtimeout, 0);
      if (i == 255) check("to_255", hif.memtimeout, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle();
    check("to_sticky", hif.memtimeout, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("to_cleared", hif.memtimeout, 0);

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have no parameters; all widths below are fixed.
REQ-002 clock  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 idexmemread  in  1  instruction in ID/EX is a load.
REQ-005 idexrt  in  5  load destination register in ID/EX.
REQ-006 ifidrs  in  5  rs of instruction in IF/ID.
REQ-007 ifidrt  in  5  rt of instruction in IF/ID.
REQ-008 ifidusesrt  in  1  IF/ID instruction reads rt as a source.
REQ-009 branchtaken  in  1  branch/jump resolved taken in EX this cycle.
REQ-010 exmemaccess  in  1  EX/MEM instruction accesses data memory.
REQ-011 dmemready  in  1  data memory completes access this cycle.
REQ-012 pcwrite  out  1  PC update enable.
REQ-013 ifidwrite  out  1  IF/ID register load enable.
REQ-014 idexbubble  out  1  load NOP into ID/EX.
REQ-015 ifidflush  out  1  clear IF/ID to NOP.
REQ-016 freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers.
REQ-017 state  out  2  current FSM state: RUN=0, LUSTALL=1, MEMWAIT=2, BRFLUSH=3.
REQ-018 stallcycles  out  16  saturating count of cycles with pcwrite=0.
REQ-019 flushcount  out  8  saturating count of branch flush events.
REQ-020 memtimeout  out  1  sticky flag: data memory wait exceeded limit.

Function
REQ-021 memstall SHALL equal exmemaccess AND NOT dmemready (combinational).
REQ-022 loaduse SHALL equal idexmemread AND idexrt!=0 AND (idexrt==ifidrs OR (ifidusesrt AND idexrt==ifidrt)), forced to 0 while state==LUSTALL.
REQ-023 Control outputs SHALL be combinational from inputs and state, with priority memstall > branchtaken > loaduse > none.
REQ-024 memstall: freeze=1, pcwrite=0, ifidwrite=0, idexbubble=0, ifidflush=0.
REQ-025 branchtaken, no memstall: pcwrite=1, ifidwrite=1, ifidflush=1, idexbubble=1, freeze=0.
REQ-026 loaduse only: pcwrite=0, ifidwrite=0, idexbubble=1, ifidflush=0, freeze=0.
REQ-027 No condition: pcwrite=1, ifidwrite=1, idexbubble=0, ifidflush=0, freeze=0.
REQ-028 Next state SHALL be MEMWAIT if memstall, else BRFLUSH if branchtaken, else LUSTALL if loaduse, else RUN; evaluated every cycle from any state.
REQ-029 stallcycles SHALL increment by 1 each cycle pcwrite=0, holding at 16'hFFFF.
REQ-030 flushcount SHALL increment once per cycle in which REQ-025 applies, holding at 8'hFF.
REQ-031 An internal 8-bit memwait counter SHALL increment each memstall cycle, clear on any non-memstall cycle, and hold at 255.
REQ-032 memtimeout SHALL be set on the edge where memwait counter reaches 255 and remain set until reset.
REQ-033 Branch during memstall SHALL NOT flush and SHALL NOT count; the EX stage is frozen, so branchtaken is re-presented after the stall.

Reset
REQ-034 While reset=1: pcwrite=0, ifidwrite=0, idexbubble=1, ifidflush=1, freeze=0, regardless of other inputs.
REQ-035 On a rising edge with reset=1: state=RUN, stallcycles=0, flushcount=0, memwait counter=0, memtimeout=0; reset mid-stall abandons the stall with no residual state.

Verification
REQ-036 idexmemread=1, idexrt=5, ifidrs=5 -> same cycle pcwrite=0, idexbubble=1; next cycle state=1, and a repeat match gives no second bubble; stallcycles=1.
REQ-037 idexmemread=1, idexrt=0, ifidrs=0 -> no stall; idexrt=7, ifidrt=7, ifidusesrt=0 -> no stall.
REQ-038 branchtaken=1 together with a loaduse match -> ifidflush=1, idexbubble=1, pcwrite=1; flushcount=1; state=3.
REQ-039 exmemaccess=1, dmemready=0 for 3 cycles, branchtaken=1 throughout -> freeze=1 for 3 cycles, flushcount unchanged, stallcycles=3, state=2.
REQ-040 dmemready=0 with exmemaccess=1 for 300 cycles -> memtimeout=1 from cycle 255 onward, cleared only by reset.
REQ-041 Assert reset mid-MEMWAIT with stallcycles=10 -> next edge state=0, all counters 0, memtimeout=0.
